// File: rtl/as_pack.sv
// Shared definitions for the RV64I EX/MEM boundary: data width, branch
// funct3 codes, the EX/MEM payload layout and the branch condition helper.
package as_pack;

    localparam int unsigned reg_width = 64;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // Default-width view of the EX/MEM payload for MEM-side consumers. The
    // stage itself packs the same field order with its own parameter widths.
    typedef struct packed {
        logic [reg_width-1:0] alu_result;
        logic [reg_width-1:0] store_data;
        logic [4:0]           rd_addr;
        logic                 reg_we;
        logic                 mem_re;
        logic                 mem_we;
    } exmem_payload_t;

    // Signed/unsigned selection already happened in the ALU op choice, so
    // BLT/BLTU and BGE/BGEU share the same flag test here.
    function automatic logic br_cond(input logic [2:0] funct3,
                                     input logic       zero,
                                     input logic       nega);
        logic taken;
        taken = 1'b0;
        case (funct3)
            BR_BEQ:           taken = zero;
            BR_BNE:           taken = !zero;
            BR_BLT, BR_BLTU:  taken = nega;
            BR_BGE, BR_BGEU:  taken = !nega;
            default:          taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/as_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// Upstream ready depends only on the skid register, never on i_ready.
module as_skid_buf #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [Width-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [Width-1:0] o_data
);

    logic             r_out_valid;
    logic [Width-1:0] r_out_data;
    logic             r_skid_valid;
    logic [Width-1:0] r_skid_data;

    logic w_accept;
    logic w_load;

    assign w_accept = i_valid && !r_skid_valid;
    assign w_load   = !r_out_valid || i_ready;

    // Output register and skid entry; skid always drains ahead of new beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (i_flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_load) begin
            if (r_skid_valid) begin
                // Ready was low this cycle, so no new beat can arrive here.
                r_out_valid  <= 1'b1;
                r_out_data   <= r_skid_data;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_accept;
                if (w_accept) begin
                    r_out_data <= i_data;
                end
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= i_data;
        end
    end

    assign o_ready = !r_skid_valid;
    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;

endmodule

// File: rtl/as_exmem_stage.sv
// EX/MEM pipeline boundary: skid-buffered payload, branch resolution with a
// registered one-cycle redirect, and synchronous flush.
// Optional statistics counters are built when AS_EXMEM_STATS_EN is defined.
module as_exmem_stage
    import as_pack::*;
#(
    parameter int unsigned REG_WIDTH = reg_width,
    parameter int unsigned RD_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic [REG_WIDTH-1:0] alu_result_i,
    input  logic                 alu_zero_i,
    input  logic                 alu_nega_i,
    input  logic [REG_WIDTH-1:0] store_data_i,
    input  logic [RD_WIDTH-1:0]  rd_addr_i,
    input  logic                 reg_we_i,
    input  logic                 mem_re_i,
    input  logic                 mem_we_i,
    input  logic                 branch_i,
    input  logic [2:0]           funct3_i,
    input  logic [REG_WIDTH-1:0] br_target_i,
    input  logic                 flush_i,
    output logic                 mem_valid_o,
    input  logic                 mem_ready_i,
    output logic [REG_WIDTH-1:0] mem_alu_result_o,
    output logic [REG_WIDTH-1:0] mem_store_data_o,
    output logic [RD_WIDTH-1:0]  mem_rd_addr_o,
    output logic                 mem_reg_we_o,
    output logic                 mem_re_o,
    output logic                 mem_we_o,
    output logic                 br_taken_o,
    output logic [REG_WIDTH-1:0] br_target_o
`ifdef AS_EXMEM_STATS_EN
    ,
    output logic [31:0]          stat_beats_o,
    output logic [31:0]          stat_taken_o,
    output logic [31:0]          stat_stall_o
`endif
);

    // Same field order as exmem_payload_t, sized by this instance's parameters.
    localparam int unsigned PayW = 2 * REG_WIDTH + RD_WIDTH + 3;

    logic [PayW-1:0] w_in_pay;
    logic [PayW-1:0] w_out_pay;
    logic            w_accept;
    logic            w_taken;

    logic                 r_br_taken;
    logic [REG_WIDTH-1:0] r_br_target;

    assign w_in_pay = {alu_result_i, store_data_i, rd_addr_i, reg_we_i, mem_re_i, mem_we_i};
    assign w_accept = ex_valid_i && ex_ready_o;
    // A beat presented during flush is discarded, so it cannot redirect.
    assign w_taken  = w_accept && !flush_i && branch_i &&
                      br_cond(funct3_i, alu_zero_i, alu_nega_i);

    as_skid_buf #(
        .Width (PayW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush_i),
        .i_valid (ex_valid_i),
        .o_ready (ex_ready_o),
        .i_data  (w_in_pay),
        .o_valid (mem_valid_o),
        .i_ready (mem_ready_i),
        .o_data  (w_out_pay)
    );

    assign {mem_alu_result_o, mem_store_data_o, mem_rd_addr_o,
            mem_reg_we_o, mem_re_o, mem_we_o} = w_out_pay;

    // Redirect pulse one cycle after acceptance, regardless of MEM backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
        end else begin
            r_br_taken <= w_taken;
            if (w_taken) begin
                r_br_target <= br_target_i;
            end
        end
    end

    assign br_taken_o  = r_br_taken;
    assign br_target_o = r_br_target;

`ifdef AS_EXMEM_STATS_EN
    logic [31:0] r_stat_beats;
    logic [31:0] r_stat_taken;
    logic [31:0] r_stat_stall;
    logic        w_stall;

    assign w_stall = mem_valid_o && !mem_ready_i;

    // Saturating event counters, cleared by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_beats <= '0;
            r_stat_taken <= '0;
            r_stat_stall <= '0;
        end else if (flush_i) begin
            r_stat_beats <= '0;
            r_stat_taken <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_accept && (r_stat_beats != '1)) begin
                r_stat_beats <= r_stat_beats + 32'd1;
            end
            if (w_taken && (r_stat_taken != '1)) begin
                r_stat_taken <= r_stat_taken + 32'd1;
            end
            if (w_stall && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_beats_o = r_stat_beats;
    assign stat_taken_o = r_stat_taken;
    assign stat_stall_o = r_stat_stall;
`endif

endmodule

// File: doc/as_exmem_stage.md
Name: as_exmem_stage

Overview:
- Downstream neighbour of the ALU in the RV64I core (as_alu).
- Captures the ALU result, its zero/negative flags and the instruction's control sideband into the EX/MEM pipeline boundary through a 2-entry skid buffer with valid/ready handshake.
- Resolves conditional branches from the ALU flags and emits a one-cycle redirect (taken pulse plus target) to fetch.
- Supports pipeline flush.

Parameters:
- REG_WIDTH, default reg_width (64, from as_pack): data path width.
- RD_WIDTH, default 5: destination register index width.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid_i  in  1  EX beat valid.
- ex_ready_o  out  1  stage can accept a beat.
- alu_result_i  in  REG_WIDTH  ALU result.
- alu_zero_i  in  1  ALU zero flag.
- alu_nega_i  in  1  ALU less-than flag. The decoder selects a signed or unsigned compare op to match funct3.
- store_data_i  in  REG_WIDTH  rs2 value for stores.
- rd_addr_i  in  RD_WIDTH  destination register.
- reg_we_i, mem_re_i, mem_we_i  in  1 each  writeback/load/store controls.
- branch_i  in  1  conditional branch instruction.
- funct3_i  in  3  branch condition code.
- br_target_i  in  REG_WIDTH  precomputed branch target.
- flush_i  in  1  discard all in-flight beats.
- mem_valid_o  out  1  MEM beat valid.
- mem_ready_i  in  1  MEM accepts the beat.
- mem_alu_result_o, mem_store_data_o  out  REG_WIDTH  registered payload.
- mem_rd_addr_o  out  RD_WIDTH  registered payload.
- mem_reg_we_o, mem_re_o, mem_we_o  out  1 each  registered payload.
- br_taken_o  out  1  one-cycle redirect pulse.
- br_target_o  out  REG_WIDTH  redirect target, valid while br_taken_o is high.

Behaviour:
- Reset (async assert, sync release): all outputs are 0 except ex_ready_o, which is 1. Both buffer entries are invalid.
- Accept: a beat is accepted when ex_valid_i && ex_ready_o at a rising edge.
- Ready: ex_ready_o = !skid_valid, driven from a register. There is no combinational path from mem_ready_i to ex_ready_o.
- Output register load: loads when (!mem_valid_o || mem_ready_i).
  - Source is the skid entry if it is valid, otherwise the accepted input beat.
  - Latency input to mem_valid_o is 1 cycle when the output register is free.
- Skid capture: if the output register is held (mem_valid_o && !mem_ready_i), an accepted beat goes to the skid entry and ex_ready_o drops the next cycle.
- Ordering: strict FIFO. Skid drains before any new beat.
- Simultaneous pop and accept with skid valid: skid moves to the output register and the new beat is refused, because ready was already low.
- Payload stability: payload outputs are stable while mem_valid_o && !mem_ready_i.
- Branch resolution on accept when branch_i = 1:
  - 000 BEQ: taken if zero.
  - 001 BNE: taken if !zero.
  - 100 BLT and 110 BLTU: taken if nega.
  - 101 BGE and 111 BGEU: taken if !nega.
  - 010 and 011: never taken.
- Branch redirect timing: br_taken_o is registered and pulses exactly 1 cycle after acceptance, independent of mem_ready_i. br_target_o is latched in the same cycle.
- Branch beats still travel to MEM with their controls as supplied; the decoder drives reg_we/mem controls to 0 for branches.
- Flush (synchronous): flush_i has priority over every other event.
  - Next edge: both entries become invalid, mem_valid_o = 0, ex_ready_o = 1.
  - A beat presented in the flush cycle is discarded and its branch pulse is suppressed.
  - A br_taken_o pulse already registered still fires.
- Reset mid-operation: all in-flight beats are lost; the stage restarts empty.

Optional Feature:
- Macro: AS_EXMEM_STATS_EN.
- When defined, three extra output ports are added, each a 32-bit saturating counter cleared by rst or flush_i:
  - stat_beats_o: accepted beats.
  - stat_taken_o: taken branches.
  - stat_stall_o: cycles with mem_valid_o && !mem_ready_i.
  - Counters hold at 32'hFFFFFFFF when saturated.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- as_pack holds:
  - reg_width.
  - Branch funct3 constants: BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU.
  - Packed struct exmem_payload_t: alu_result, store_data, rd_addr, reg_we, mem_re, mem_we.
- Sub-module as_skid_buf: generic 2-entry valid/ready skid buffer, parameterised by payload width, with a flush input.
- as_exmem_stage instantiates as_skid_buf and adds branch resolution and the optional stats.

Test Plan:
- Reset: assert rst for 20 ns mid-stream -> mem_valid_o = 0, br_taken_o = 0, ex_ready_o = 1 immediately (async); first beat after release appears 1 cycle after accept.
- Streaming, mem_ready_i = 1: alu_result = 64'h19, rd = 5, reg_we = 1 -> next cycle mem_valid_o = 1, mem_alu_result_o = 64'h19, mem_rd_addr_o = 5. Back-to-back beats A, B, C arrive in order with no bubbles.
- Backpressure: hold mem_ready_i = 0 while sending A, B -> A held in output, B in skid, ex_ready_o = 0. Release -> A, then B, each one cycle apart; ex_ready_o returns to 1 one cycle after B is promoted.
- Branches:
  - BEQ with zero = 1, target 64'h1000 -> br_taken_o pulses one cycle, br_target_o = 64'h1000.
  - BNE with zero = 1 -> no pulse.
  - BLTU with nega = 1 -> pulse.
  - funct3 = 010 -> no pulse.
- Flush: output and skid full, assert flush_i together with a valid BEQ taken beat -> next cycle mem_valid_o = 0, ex_ready_o = 1, no br_taken_o pulse.
- Stats (AS_EXMEM_STATS_EN defined): 3 beats including 1 taken branch and 2 stall cycles -> stat_beats_o = 3, stat_taken_o = 1, stat_stall_o = 2. After flush_i, all counters read 0.
